// File: rtl/carfield_pkg.sv
// rtl/carfield_pkg.sv - shared constants and types for the UART receive monitor
package carfield_pkg;

  localparam int unsigned UartMonClkDivDefault = 1736;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_mon_state_e;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous FIFO; a pop on a full FIFO frees room for a same-cycle push
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH:0] FullCount = (ADDR_DEPTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - 8N1 UART receiver with byte FIFO, frame-error and overflow flags
module uart_rx_monitor
  import carfield_pkg::*;
#(
  parameter int unsigned ClkDiv    = UartMonClkDivDefault,
  parameter int unsigned FifoDepth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  input  logic       en_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overflow_o
);

  localparam int unsigned   CntW    = $clog2(ClkDiv);
  localparam logic [CntW-1:0] HalfMax = CntW'(ClkDiv / 2 - 1);
  localparam logic [CntW-1:0] BitMax  = CntW'(ClkDiv - 1);

  uart_mon_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta, rx_s, rx_prev;
  logic [1:0]      settle_q;
  logic            fall, push, pop, frame_err, frame_err_q, overflow_q;
  logic            fifo_full, fifo_empty;

  // The synchronizer comes out of reset at 1, so edge detection waits until
  // rx_prev holds a genuinely sampled line value; a line already low at
  // reset release must not look like a fresh start bit.
  assign fall = rx_prev && !rx_s && (settle_q == 2'd3);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      settle_q    <= 2'd0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rx_meta     <= rx_i;
      rx_s        <= rx_meta;
      rx_prev     <= rx_s;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_err = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          bit_d = '0;
          if (fall) state_d = START;
        end
        START: begin
          if (cnt_q == HalfMax) begin
            cnt_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q == BitMax) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end
        end
        STOP: begin
          if (cnt_q == BitMax) begin
            cnt_d = '0;
            if (rx_s) begin
              push    = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err = 1'b1;
              state_d   = BREAK;
            end
          end
        end
        BREAK: begin
          cnt_d = '0;
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign valid_o     = !fifo_empty;
  assign pop         = valid_o && ready_i;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

  fifo_v3 #(
    .DATA_WIDTH (8),
    .DEPTH      (FifoDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (shift_q),
    .push_i  (push),
    .data_o  (data_o),
    .pop_i   (pop)
  );

endmodule

// File: doc/uart_rx_monitor.md
UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 SHALL have parameter ClkDiv, default 1736 (200 MHz / 115200 baud), giving clock cycles per UART bit; legal range is at least 4, even.
REQ-002 SHALL have parameter FifoDepth, default 4, giving the number of buffered received bytes; legal values are powers of two, at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port rx_i, input, 1 bit: asynchronous serial line from the DUT uart_tx_o; idle level is high.
REQ-006 SHALL have port en_i, input, 1 bit: receive enable.
REQ-007 SHALL have port data_o, output, 8 bits: byte at the FIFO head.
REQ-008 SHALL have port valid_o, output, 1 bit: data_o is valid.
REQ-009 SHALL have port ready_i, input, 1 bit: consumer accepts data_o.
REQ-010 SHALL have port frame_err_o, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a byte is dropped because the FIFO is full.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer (rx_s) before all use; the synchronizer resets to 1.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, STOP, BREAK, using a bit counter (0..7) and a cycle counter of width $clog2(ClkDiv).
REQ-014 IDLE -> START SHALL occur on the cycle t0 at which rx_s is 0, its previous value was 1, and en_i is 1; the cycle counter clears at t0.
REQ-015 In START, rx_s SHALL be sampled at t0+ClkDiv/2: a 0 goes to DATA; a 1 is a glitch and returns to IDLE with no output.
REQ-016 In DATA, data bit i (i = 0..7, LSB first) SHALL be sampled at t0+ClkDiv/2+(i+1)*ClkDiv and shifted into the byte register.
REQ-017 STOP SHALL sample rx_s at t0+ClkDiv/2+9*ClkDiv.
REQ-018 A stop sample of 1 SHALL push the byte into the FIFO and return to IDLE; valid_o rises on the next cycle when the FIFO was empty.
REQ-019 A stop sample of 0 SHALL pulse frame_err_o for 1 cycle, discard the byte, and enter BREAK.
REQ-020 BREAK SHALL wait for rx_s to be 1, then go to IDLE.
REQ-021 A push while the FIFO is full SHALL drop the new byte and set overflow_o; existing FIFO contents are unchanged.
REQ-022 When a push and a pop occur in the same cycle on a full FIFO, the pop SHALL be applied first and the push accepted, with no overflow.
REQ-023 The output handshake SHALL follow valid/ready: a pop occurs when valid_o and ready_i are both 1; data_o is held stable while valid_o is 1 and ready_i is 0.
REQ-024 valid_o SHALL equal "FIFO not empty"; data_o SHALL be the FIFO head and is don't-care when valid_o is 0.
REQ-025 en_i deasserted in any state SHALL force the FSM to IDLE on the next cycle and discard the partial byte; FIFO contents and overflow_o are kept.
REQ-026 FIFO read and write pointers SHALL wrap modulo FifoDepth.

Reset
REQ-027 Reset SHALL be synchronous on rst_ni low, taking effect at the next clk_i edge.
REQ-028 After reset, the FSM SHALL be in IDLE, all counters 0, the FIFO empty, and valid_o, frame_err_o and overflow_o all 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no push and no frame_err_o pulse; reception restarts only on a fresh falling edge after reset.

Structure
REQ-030 The FSM state enum and the default ClkDiv constant (UartMonClkDivDefault) SHALL live in carfield_pkg.
REQ-031 Buffering SHALL use a single sub-module instance of common_cells fifo_v3 (DATA_WIDTH 8, DEPTH FifoDepth), with flush tied to 0.
REQ-032 The block SHALL contain no other sub-modules and SHALL be synthesizable.

Verification (ClkDiv=16, FifoDepth=4)
REQ-033 Send 0x41 (8N1, 16 cycles/bit) with ready_i=1 -> data_o=0x41 and valid_o=1 for exactly 1 cycle, rising at t0+153.
REQ-034 Send 0x00, 0xFF, 0xA5, 0x5A, 0x3C back-to-back with ready_i=0 -> FIFO holds 0x00, 0xFF, 0xA5, 0x5A; 0x3C is dropped and overflow_o=1; draining yields those 4 bytes in order.
REQ-035 Send a frame for 0x55 with the stop bit forced low for 20 bits -> frame_err_o pulses once, no push occurs, and no new start is detected until the line returns high.
REQ-036 Drive a 4-cycle low glitch on an idle line -> returns to IDLE, valid_o stays 0, frame_err_o stays 0.
REQ-037 Assert rst_ni=0 during bit 4 of 0xC3, then send 0x12 -> only 0x12 is received and all flags are 0.
REQ-038 Drop en_i during bit 2, re-raise it, then send 0x7E -> only 0x7E is received.
